// File: rtl/spi_memory_bridge.sv
// SPI mode-0, LSB-first slave that turns framed SPI transactions into
// single-cycle read/write strobes on a parallel memory port with auto-increment.
module spi_memory_bridge #(
    parameter int ADDR_WIDTH  = 15,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  _reset,
    input  logic                  _select,
    input  logic                  sck,
    input  logic                  mosi,
    output logic                  miso,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd,
    output logic                  wr
);

    localparam int              CW   = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, ADDR_LO, ADDR_HI, WRITE, READ} state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_sel_sync;
    logic                   r_sck_prev;
    logic                   r_sel_prev;

    state_t                 r_state;
    logic [CW-1:0]          r_bit_cnt;
    logic [DATA_WIDTH-2:0]  r_rx;
    logic [DATA_WIDTH-2:0]  r_tx;
    logic                   r_miso;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_data_out;
    logic                   r_rd;
    logic                   r_wr;
    logic                   r_rd_d;
    logic                   r_inc_pending;

    logic                   w_sck;
    logic                   w_mosi;
    logic                   w_sel;
    logic                   w_sck_rise;
    logic                   w_sck_fall;
    logic                   w_sel_fall;
    logic                   w_sel_rise;
    logic                   w_byte_done;
    logic [DATA_WIDTH-1:0]  w_byte;

    assign w_sck       = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sel       = r_sel_sync[SYNC_STAGES-1];
    assign w_sck_rise  = w_sck & ~r_sck_prev;
    assign w_sck_fall  = ~w_sck & r_sck_prev;
    assign w_sel_fall  = ~w_sel & r_sel_prev;
    assign w_sel_rise  = w_sel & ~r_sel_prev;
    assign w_byte      = {w_mosi, r_rx};
    assign w_byte_done = w_sck_rise && (r_bit_cnt == LAST);

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_sel_sync  <= '1;
            r_sck_prev  <= 1'b0;
            r_sel_prev  <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sel_sync  <= {r_sel_sync[SYNC_STAGES-2:0], _select};
            r_sck_prev  <= w_sck;
            r_sel_prev  <= w_sel;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_rx          <= '0;
            r_tx          <= '0;
            r_miso        <= 1'b0;
            r_addr        <= '0;
            r_data_out    <= '0;
            r_rd          <= 1'b0;
            r_wr          <= 1'b0;
            r_rd_d        <= 1'b0;
            r_inc_pending <= 1'b0;
        end else begin
            r_rd   <= 1'b0;
            r_wr   <= 1'b0;
            r_rd_d <= r_rd;
            if (r_inc_pending) begin
                r_addr        <= r_addr + 1'b1;
                r_inc_pending <= 1'b0;
            end
            if (w_sel_rise) begin
                r_state   <= IDLE;
                r_bit_cnt <= '0;
                r_miso    <= 1'b0;
                r_rd_d    <= 1'b0;
            end else begin
                if (r_state != IDLE && w_sck_rise) begin
                    r_rx      <= w_byte[DATA_WIDTH-1:1];
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                case (r_state)
                    IDLE: begin
                        if (w_sel_fall) begin
                            r_state   <= ADDR_LO;
                            r_bit_cnt <= '0;
                        end
                    end
                    ADDR_LO: begin
                        if (w_byte_done) begin
                            r_addr[7:0] <= w_byte;
                            r_state     <= ADDR_HI;
                        end
                    end
                    ADDR_HI: begin
                        if (w_byte_done) begin
                            r_addr[ADDR_WIDTH-1:8] <= w_byte[ADDR_WIDTH-9:0];
                            if (w_byte[DATA_WIDTH-1]) begin
                                r_state <= WRITE;
                            end else begin
                                r_state <= READ;
                                r_rd    <= 1'b1;
                            end
                        end
                    end
                    WRITE: begin
                        if (w_byte_done) begin
                            r_data_out    <= w_byte;
                            r_wr          <= 1'b1;
                            r_inc_pending <= 1'b1;
                        end
                    end
                    READ: begin
                        // The fall right after a byte's last rise is skipped:
                        // the reload supplies bit 0 of the next byte instead.
                        if (w_byte_done) begin
                            r_addr <= r_addr + 1'b1;
                            r_rd   <= 1'b1;
                        end else if (w_sck_fall && r_bit_cnt != '0) begin
                            r_miso <= r_tx[0];
                            r_tx   <= r_tx >> 1;
                        end
                        if (r_rd_d) begin
                            r_tx   <= data_in[DATA_WIDTH-1:1];
                            r_miso <= data_in[0];
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign miso     = r_miso;
    assign addr     = r_addr;
    assign data_out = r_data_out;
    assign rd       = r_rd;
    assign wr       = r_wr;

endmodule

// File: tb/tb_spi_memory_bridge.sv
// Directed and randomized SPI transactions against a queue/array reference
// model of the bridge's memory-side behaviour.
module tb_spi_memory_bridge;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        _reset;
    logic        _select;
    logic        sck;
    logic        mosi;
    logic        miso;
    logic [14:0] addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        rd;
    logic        wr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_memory_bridge #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        ._reset   (_reset),
        ._select  (_select),
        .sck      (sck),
        .mosi     (mosi),
        .miso     (miso),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .rd       (rd),
        .wr       (wr)
    );

    // Memory seen by the DUT: unwritten locations read back as addr[7:0].
    bit [7:0] mem [32768];
    bit       mem_written [32768];
    always @(posedge clk) begin
        if (rd) data_in <= mem_written[int'(addr)] ? mem[int'(addr)] : addr[7:0];
        if (wr) begin
            mem[int'(addr)]         <= data_out;
            mem_written[int'(addr)] <= 1'b1;
        end
    end

    // Reference model memory, maintained from expected writes only.
    bit [7:0] model_mem [32768];
    bit       model_written [32768];

    function automatic logic [7:0] model_rd(input int a);
        return model_written[a] ? model_mem[a] : a[7:0];
    endfunction

    int rd_q[$];
    int wr_q[$];

    always @(negedge clk) begin
        if (rd) rd_q.push_back(int'(addr));
        if (wr) wr_q.push_back(int'(addr) * 256 + int'(data_out));
        if (rd || wr) begin
            checks++;
            assert (!(rd && wr)) else begin
                failures++;
                $error("FAIL rd_wr_exclusive observed rd=%0b wr=%0b expected not both", rd, wr);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nb, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nb; i++) begin
            mosi = b[i];
            repeat (HALF) @(negedge clk);
            r[i] = miso;
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    logic [7:0] tx_data [8];
    logic [7:0] rx_data [8];

    task automatic run_txn(input bit is_wr, input logic [14:0] base, input int n);
        logic [7:0] r;
        rd_q.delete();
        wr_q.delete();
        _select = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(base[7:0], 8, r);
        chk("hdr_lo_miso", {24'h0, r}, 32'h0);
        spi_bits({is_wr, base[14:8]}, 8, r);
        chk("hdr_hi_miso", {24'h0, r}, 32'h0);
        for (int i = 0; i < n; i++) begin
            spi_bits(is_wr ? tx_data[i] : 8'($urandom), 8, r);
            rx_data[i] = r;
        end
        repeat (HALF) @(negedge clk);
        _select = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic verify_txn(input bit is_wr, input logic [14:0] base, input int n);
        int a;
        if (is_wr) begin
            chk("wr_count", wr_q.size(), n);
            chk("rd_count_in_write", rd_q.size(), 0);
            for (int i = 0; i < n; i++) begin
                a = (int'(base) + i) % 32768;
                chk("wr_addr_data", wr_q[i], a * 256 + int'(tx_data[i]));
                chk("miso_in_write", {24'h0, rx_data[i]}, 32'h0);
                model_mem[a]     = tx_data[i];
                model_written[a] = 1'b1;
            end
        end else begin
            chk("rd_count", rd_q.size(), n + 1);
            chk("wr_count_in_read", wr_q.size(), 0);
            for (int i = 0; i <= n; i++)
                chk("rd_addr", rd_q[i], (int'(base) + i) % 32768);
            for (int i = 0; i < n; i++)
                chk("miso_byte", {24'h0, rx_data[i]}, {24'h0, model_rd((int'(base) + i) % 32768)});
        end
        chk("final_addr", {17'h0, addr}, (int'(base) + n) % 32768);
    endtask

    initial begin
        logic [7:0]  r;
        logic [14:0] base;
        logic [14:0] last_wr_base;
        bit          is_wr;
        int          n;

        _reset = 1'b0; _select = 1'b1; sck = 1'b0; mosi = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_addr", {17'h0, addr}, 32'h0);
        chk("reset_data_out", {24'h0, data_out}, 32'h0);
        chk("reset_rd_wr_miso", {29'h0, rd, wr, miso}, 32'h0);
        _reset = 1'b1;
        repeat (4) @(negedge clk);

        tx_data[0] = 8'h01; tx_data[1] = 8'h02; tx_data[2] = 8'h04; tx_data[3] = 8'h08;
        run_txn(1'b1, 15'h5EAD, 4);
        chk("plan_write_last", wr_q[3], 32'h5EB0 * 256 + 32'h08);
        verify_txn(1'b1, 15'h5EAD, 4);

        run_txn(1'b0, 15'h5AFE, 4);
        chk("plan_read_b0", {24'h0, rx_data[0]}, 32'hFE);
        chk("plan_read_b3", {24'h0, rx_data[3]}, 32'h01);
        verify_txn(1'b0, 15'h5AFE, 4);

        run_txn(1'b0, 15'h7FFE, 4);
        chk("plan_wrap_rd", rd_q[2], 32'h0);
        chk("plan_wrap_b2", {24'h0, rx_data[2]}, 32'h00);
        verify_txn(1'b0, 15'h7FFE, 4);

        tx_data[0] = 8'h11; tx_data[1] = 8'h22; tx_data[2] = 8'h44; tx_data[3] = 8'h88;
        run_txn(1'b1, 15'h7FFE, 4);
        chk("plan_wrap_wr", wr_q[2], 32'h44);
        verify_txn(1'b1, 15'h7FFE, 4);

        // Write frame aborted four bits into its second data byte.
        rd_q.delete(); wr_q.delete();
        _select = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h90, 8, r);
        spi_bits(8'hAA, 8, r);
        spi_bits(8'h33, 4, r);
        repeat (HALF) @(negedge clk);
        _select = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        chk("abort_wr_count", wr_q.size(), 1);
        chk("abort_wr_first", wr_q[0], 32'h1000 * 256 + 32'hAA);
        chk("abort_addr_hold", {17'h0, addr}, 32'h1001);
        model_mem[32'h1000] = 8'hAA; model_written[32'h1000] = 1'b1;
        run_txn(1'b0, 15'h1000, 2);
        verify_txn(1'b0, 15'h1000, 2);

        // Asynchronous reset in the middle of a write frame.
        rd_q.delete(); wr_q.delete();
        _select = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(8'h34, 8, r);
        spi_bits(8'h92, 8, r);
        spi_bits(8'h55, 8, r);
        spi_bits(8'hF0, 3, r);
        chk("pre_reset_wr", wr_q[0], 32'h1234 * 256 + 32'h55);
        model_mem[32'h1234] = 8'h55; model_written[32'h1234] = 1'b1;
        @(posedge clk);
        #3 _reset = 1'b0;
        #1;
        chk("async_reset_addr", {17'h0, addr}, 32'h0);
        chk("async_reset_data_out", {24'h0, data_out}, 32'h0);
        chk("async_reset_rd_wr_miso", {29'h0, rd, wr, miso}, 32'h0);
        _select = 1'b1; sck = 1'b0;
        repeat (4) @(negedge clk);
        _reset = 1'b1;
        repeat (4) @(negedge clk);
        run_txn(1'b0, 15'h1233, 3);
        verify_txn(1'b0, 15'h1233, 3);

        last_wr_base = 15'h7FFF;
        for (int k = 0; k < 8; k++) begin
            is_wr = (k % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            base  = (k == 2) ? 15'h7FFD : 15'($urandom);
            if (k % 2 == 1) begin
                is_wr = 1'b0;
                base  = last_wr_base;
            end
            n = $urandom_range(1, 5);
            for (int i = 0; i < 8; i++) tx_data[i] = 8'($urandom);
            run_txn(is_wr, base, n);
            verify_txn(is_wr, base, n);
            if (is_wr) last_wr_base = base;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
